uart_tx_ctrl: RTL and testbench

// - UART transmit sequencer. Accepts a parallel word via a ready/start handshake and serialises it on txd.
// - Frame format: start bit, DBITS data bits LSB first, optional parity bit, one stop bit.
// - Owns and sequences the baud bit timer: enables it per frame and advances the FSM on each bit tick.
// - Sits between the host-side TX register and the txd pad.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_ctrl_bit_timer.sv | 30 +++
 rtl/uart_tx_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit sequencer.
package uart_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    // Parity mode encodings for the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Parity bit for a data word.
    // The word is zero-extended to 9 bits, and the extra zeros leave the XOR unchanged.
    function automatic logic calc_parity(input logic [8:0] data, input int mode);
        logic p;
        case (mode)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_bit_timer.sv
// Baud bit timer: counts 0..div and flags the last cycle of each bit period.
module bit_timer #(
    parameter int BBITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [BBITS-1:0] div,
    output logic             bit_tick
);

    logic [BBITS-1:0] cnt_r;

    // Cycle counter. It is held at zero while disabled or cleared, and it wraps after reaching div.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {BBITS{1'b0}};
        end else if (clr || !en) begin
            cnt_r <= {BBITS{1'b0}};
        end else if (cnt_r == div) begin
            cnt_r <= {BBITS{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(BBITS-1){1'b0}}, 1'b1};
        end
    end

    assign bit_tick = en & (cnt_r == div);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer.
// It takes a word through a ready/start handshake and sends start, data (LSB first),
// optional parity, and stop bits on txd.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int BBITS  = 16,
    parameter int DBITS  = 8,
    parameter int PARITY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BBITS-1:0] baud_div,
    input  logic             tx_start,
    input  logic [DBITS-1:0] tx_data,
    output logic             tx_ready,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             txd
);

    localparam int CW = $clog2(DBITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DBITS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_r, state_s;
    logic [DBITS-1:0] shreg_r, shreg_s;
    logic [CW-1:0]    bit_cnt_r, bit_cnt_s;
    logic [BBITS-1:0] div_r, div_s;
    logic             par_r, par_s;
    logic             txd_r, txd_s;
    logic             done_s;
    logic             accept_s;
    logic             bit_tick_s;
    logic             timer_en_s;

    assign accept_s   = tx_start & (state_r == IDLE);
    assign timer_en_s = (state_r != IDLE);

    bit_timer #(.BBITS(BBITS)) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (timer_en_s),
        .clr      (accept_s),
        .div      (div_r),
        .bit_tick (bit_tick_s)
    );

    // Next-state logic for the FSM, shift register, bit counter and latched frame settings
    always_comb begin
        state_s   = state_r;
        shreg_s   = shreg_r;
        bit_cnt_s = bit_cnt_r;
        div_s     = div_r;
        par_s     = par_r;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s   = START;
                    shreg_s   = tx_data;
                    div_s     = baud_div;
                    par_s     = calc_parity(9'(tx_data), PARITY);
                    bit_cnt_s = {CW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_tick_s) begin
                    state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bit_tick_s) begin
                    shreg_s = {1'b0, shreg_r[DBITS-1:1]};
                    if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_s = {CW{1'b0}};
                        state_s   = (PARITY != PAR_NONE) ? PAR : STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PAR: begin
                if (bit_tick_s) begin
                    state_s = STOP;
                end else begin
                    state_s = PAR;
                end
            end
            STOP: begin
                if (bit_tick_s) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle. It is derived from the next state so that txd lines up with state.
    always_comb begin
        txd_s = 1'b1;
        case (state_s)
            START:   txd_s = 1'b0;
            DATA:    txd_s = shreg_s[0];
            PAR:     txd_s = par_s;
            STOP:    txd_s = 1'b1;
            IDLE:    txd_s = 1'b1;
            default: txd_s = 1'b1;
        endcase
    end

    // State and datapath registers. txd resets high so an aborted frame never drives a spurious 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            shreg_r   <= {DBITS{1'b0}};
            bit_cnt_r <= {CW{1'b0}};
            div_r     <= {BBITS{1'b0}};
            par_r     <= 1'b0;
            txd_r     <= 1'b1;
        end else begin
            state_r   <= state_s;
            shreg_r   <= shreg_s;
            bit_cnt_r <= bit_cnt_s;
            div_r     <= div_s;
            par_r     <= par_s;
            txd_r     <= txd_s;
        end
    end

    assign tx_ready = (state_r == IDLE);
    assign tx_busy  = (state_r != IDLE);
    assign tx_done  = done_s;
    assign txd      = txd_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl.
// Three instances (no parity, even parity, odd parity) share one clock and one reset.
// Expected txd levels are queued per cycle when a frame is requested and popped as the line is observed.
module tb_uart_tx_ctrl;

    logic        clk;
    logic        rst_n;
    logic [2:0]  tx_start;
    logic [7:0]  tx_data  [3];
    logic [15:0] baud_div [3];
    logic [2:0]  tx_ready;
    logic [2:0]  tx_busy;
    logic [2:0]  tx_done;
    logic [2:0]  txd;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    logic exp_q[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_tx_ctrl #(.BBITS(16), .DBITS(8), .PARITY(g)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .baud_div (baud_div[g]),
            .tx_start (tx_start[g]),
            .tx_data  (tx_data[g]),
            .tx_ready (tx_ready[g]),
            .tx_busy  (tx_busy[g]),
            .tx_done  (tx_done[g]),
            .txd      (txd[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the expected per-cycle line level of one frame. Instance index d equals its parity mode.
    task automatic push_frame(input int d, input logic [7:0] data, input logic [15:0] div);
        logic fb[$];
        fb.push_back(1'b0);
        for (int i = 0; i < 8; i++) fb.push_back(data[i]);
        if (d == 1) fb.push_back(^data);
        if (d == 2) fb.push_back(~^data);
        fb.push_back(1'b1);
        foreach (fb[k]) begin
            for (int c = 0; c <= int'(div); c++) exp_q.push_back(fb[k]);
        end
    endtask

    task automatic start_frame(input int d, input logic [7:0] data, input logic [15:0] div);
        @(negedge clk);
        chk("ready_before_accept", tx_ready[d], 1);
        tx_start[d] = 1'b1;
        tx_data[d]  = data;
        baud_div[d] = div;
        push_frame(d, data, div);
    endtask

    // Pop and compare one expected level per cycle.
    // Optional actions: change inputs at cycle mid_i, and stop early after stop_at cycles.
    task automatic watch_frame(input int d, input bit hold, input int mid_i,
                               input logic [7:0] new_data, input logic [15:0] new_div,
                               input int stop_at, input string tag);
        int   i;
        logic e;
        i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (i == 0 && !hold) tx_start[d] = 1'b0;
            if (i == mid_i) begin
                tx_data[d]  = new_data;
                baud_div[d] = new_div;
            end
            e = exp_q.pop_front();
            chk($sformatf("%s_txd_c%0d", tag, i), txd[d], e);
            chk($sformatf("%s_done_c%0d", tag, i), tx_done[d], exp_q.size() == 0);
            chk($sformatf("%s_busy_c%0d", tag, i), tx_busy[d], 1);
            i++;
            if (i == stop_at) return;
        end
        @(negedge clk);
        chk({tag, "_ready_after"}, tx_ready[d], 1);
        chk({tag, "_txd_idle"}, txd[d], 1);
        chk({tag, "_done_low"}, tx_done[d], 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_start = 3'b000;
        for (int k = 0; k < 3; k++) begin
            tx_data[k]  = 8'h00;
            baud_div[k] = 16'h0000;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready%0d", k), tx_ready[k], 1);
            chk($sformatf("rst_busy%0d", k), tx_busy[k], 0);
            chk($sformatf("rst_txd%0d", k), txd[k], 1);
            chk($sformatf("rst_done%0d", k), tx_done[k], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // 8N1, 4 clk per bit, 0xA5
        start_frame(0, 8'hA5, 16'd3);
        watch_frame(0, 1'b0, -1, 8'h00, 16'd0, -1, "a5_8n1");

        // Even and odd parity on 0x07, 2 clk per bit
        start_frame(1, 8'h07, 16'd1);
        watch_frame(1, 1'b0, -1, 8'h00, 16'd0, -1, "even07");
        start_frame(2, 8'h07, 16'd1);
        watch_frame(2, 1'b0, -1, 8'h00, 16'd0, -1, "odd07");

        // One cycle per bit
        start_frame(0, 8'h00, 16'd0);
        watch_frame(0, 1'b0, -1, 8'h00, 16'd0, -1, "div0");

        // tx_start held throughout, data switched to 0xFF mid-frame, then the back-to-back frame
        start_frame(0, 8'hA5, 16'd3);
        watch_frame(0, 1'b1, 10, 8'hFF, 16'd3, -1, "hold1");
        push_frame(0, 8'hFF, 16'd3);
        watch_frame(0, 1'b0, -1, 8'h00, 16'd0, -1, "hold2");

        // baud_div switched mid-frame, which only affects the next frame
        start_frame(0, 8'h3C, 16'd3);
        watch_frame(0, 1'b0, 5, 8'h3C, 16'd7, -1, "divchg1");
        start_frame(0, 8'h3C, 16'd7);
        watch_frame(0, 1'b0, -1, 8'h00, 16'd0, -1, "divchg2");

        // Reset during data bit 4 (txd low at that point for 0xA5)
        start_frame(0, 8'hA5, 16'd3);
        watch_frame(0, 1'b0, -1, 8'h00, 16'd0, 22, "prerst");
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_txd", txd[0], 1);
        chk("midrst_busy", tx_busy[0], 0);
        chk("midrst_ready", tx_ready[0], 1);
        chk("midrst_done", tx_done[0], 0);
        exp_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("postrst_txd%0d", c), txd[0], 1);
            chk($sformatf("postrst_done%0d", c), tx_done[0], 0);
            chk($sformatf("postrst_busy%0d", c), tx_busy[0], 0);
        end
        start_frame(0, 8'h96, 16'd2);
        watch_frame(0, 1'b0, -1, 8'h00, 16'd0, -1, "afterrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound on the whole run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
